// File: rtl/event_recorder_pkg.sv
// ============================================================================
// Module      : event_recorder_pkg
// Description : Shared types and helpers for the event recorder: severity
//               encoding, level normalisation, recorder state, counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package event_recorder_pkg;

    // Counter width for the error and drop statistics
    localparam int CNT_W = 16;

    // Severity encoding, ordered from least to most severe
    typedef enum logic [2:0] {
        SEV_TRACE = 3'd0,
        SEV_DEBUG = 3'd1,
        SEV_INFO  = 3'd2,
        SEV_WARN  = 3'd3,
        SEV_ERROR = 3'd4,
        SEV_FATAL = 3'd5
    } severity_t;

    // Recorder lifecycle
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } rec_state_t;

    // Codes 6 and 7 have no meaning and are folded onto TRACE
    function automatic severity_t normalize_level(input logic [2:0] raw);
        if (raw > 3'd5) begin
            return SEV_TRACE;
        end
        return severity_t'(raw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
// ============================================================================
// Module      : event_fifo
// Description : Synchronous first-word-fall-through FIFO. A push is accepted
//               while full when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care while empty so it has no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_recorder.sv
// ============================================================================
// Module      : event_recorder
// Description : Timestamps, filters and buffers checker events, drains them on
//               a valid/ready stream, keeps error/drop statistics and raises a
//               sticky halt once a FATAL event has been fully drained.
//               Optional macro EVENT_RECORDER_SEQ_EN adds a per-event sequence
//               number and the out_seq port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_recorder
    import event_recorder_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TOPIC_W   = 8,
    parameter int DATA_W    = 32,
    parameter int TS_W      = 32,
    parameter int MIN_LEVEL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2:0]         in_level,
    input  logic [TOPIC_W-1:0] in_topic,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_level,
    output logic [TOPIC_W-1:0] out_topic,
    output logic [DATA_W-1:0]  out_data,
    output logic [TS_W-1:0]    out_time,
    output logic [CNT_W-1:0]   error_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               halt
`ifdef EVENT_RECORDER_SEQ_EN
    ,
    output logic [15:0]        out_seq
`endif
);

`ifdef EVENT_RECORDER_SEQ_EN
    localparam int SEQ_W = 16;
`else
    localparam int SEQ_W = 0;
`endif
    localparam int ENTRY_W = SEQ_W + 3 + TOPIC_W + DATA_W + TS_W;
    localparam int CW      = $clog2(DEPTH + 1);
    // Bit n set means normalised level n passes the filter
    localparam logic [7:0] PASS_MASK = 8'hFF << MIN_LEVEL;

    rec_state_t           state;
    logic [TS_W-1:0]      timestamp;
    logic [2:0]           lvl_n;
    logic                 passes;
    logic                 accept;
    logic                 is_err;
    logic                 is_fatal;
    logic                 head_valid;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   rd_entry;

    assign lvl_n    = normalize_level(in_level);
    assign passes   = PASS_MASK[lvl_n];
    assign accept   = in_valid && passes && (state == ST_RUN);
    assign is_err   = (lvl_n == SEV_ERROR) || (lvl_n == SEV_FATAL);
    assign is_fatal = (lvl_n == SEV_FATAL);

    assign head_valid = !fifo_empty && (state != ST_HALTED);
    assign pop        = head_valid && out_ready;
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;

`ifdef EVENT_RECORDER_SEQ_EN
    logic [15:0] seq;

    // Sequence number advances on every accepted event, stored or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else if (accept) begin
            seq <= seq + 1'b1;
        end
    end

    assign wr_entry = {seq, lvl_n, in_topic, in_data, timestamp};
    assign out_seq  = head_valid ? rd_entry[ENTRY_W-1 -: 16] : '0;
`else
    assign wr_entry = {lvl_n, in_topic, in_data, timestamp};
`endif

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields read as zero whenever nothing is presented
    assign out_valid = head_valid;
    assign out_time  = head_valid ? rd_entry[TS_W-1:0] : '0;
    assign out_data  = head_valid ? rd_entry[TS_W +: DATA_W] : '0;
    assign out_topic = head_valid ? rd_entry[TS_W+DATA_W +: TOPIC_W] : '0;
    assign out_level = head_valid ? rd_entry[TS_W+DATA_W+TOPIC_W +: 3] : '0;

    // Free-running cycle timestamp, held at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timestamp <= '0;
        end else if (timestamp != '1) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count <= '0;
            drop_count  <= '0;
        end else begin
            if (accept && is_err && (error_count != '1)) begin
                error_count <= error_count + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Lifecycle: a FATAL stops intake, halt rises the cycle after the last pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            halt  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && is_fatal) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty || (pop && (fifo_count == CW'(1)))) begin
                        state <= ST_HALTED;
                        halt  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= ST_HALTED;
                    halt  <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_event_recorder.sv
// ============================================================================
// Module      : tb_event_recorder
// Description : Self-checking bench for event_recorder against a queue-based
//               reference model. Honours EVENT_RECORDER_SEQ_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_recorder;

    localparam int DEPTH     = 16;
    localparam int MIN_LEVEL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_level = '0;
    logic [7:0]  in_topic = '0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [2:0]  out_level;
    logic [7:0]  out_topic;
    logic [31:0] out_data;
    logic [31:0] out_time;
    logic [15:0] error_count;
    logic [15:0] drop_count;
    logic        halt;
`ifdef EVENT_RECORDER_SEQ_EN
    logic [15:0] out_seq;
`endif

    event_recorder #(
        .DEPTH     (DEPTH),
        .TOPIC_W   (8),
        .DATA_W    (32),
        .TS_W      (32),
        .MIN_LEVEL (MIN_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_level    (in_level),
        .in_topic    (in_topic),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_level   (out_level),
        .out_topic   (out_topic),
        .out_data    (out_data),
        .out_time    (out_time),
        .error_count (error_count),
        .drop_count  (drop_count),
        .halt        (halt)
`ifdef EVENT_RECORDER_SEQ_EN
        ,
        .out_seq     (out_seq)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  lvl;
        logic [7:0]  topic;
        logic [31:0] data;
        logic [31:0] ts;
        logic [15:0] seq;
    } ev_t;

    ev_t         q[$];
    logic [31:0] m_ts;
    logic [15:0] m_seq;
    int          m_err;
    int          m_drop;
    bit          m_fatal;
    bit          m_halted;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts     = '0;
        m_seq    = '0;
        m_err    = 0;
        m_drop   = 0;
        m_fatal  = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock edge worth of behaviour, written from the event-level rules
    task automatic model_clock(input logic v, input logic [2:0] lvl, input logic [7:0] topic,
                               input logic [31:0] data, input logic rdy);
        int         pre;
        bit         pop;
        bit         acc;
        bit         fatal_now;
        logic [2:0] nl;
        pre       = q.size();
        pop       = (pre > 0) && !m_halted && rdy;
        nl        = (lvl > 3'd5) ? 3'd0 : lvl;
        acc       = v && (int'(nl) >= MIN_LEVEL) && !m_fatal;
        fatal_now = 1'b0;
        if (pop) begin
            void'(q.pop_front());
        end
        if (acc) begin
            if (pre < DEPTH || pop) begin
                q.push_back('{lvl: nl, topic: topic, data: data, ts: m_ts, seq: m_seq});
            end else if (m_drop < 65535) begin
                m_drop++;
            end
            if (nl >= 3'd4 && m_err < 65535) begin
                m_err++;
            end
            if (nl == 3'd5) begin
                fatal_now = 1'b1;
            end
            m_seq = m_seq + 16'd1;
        end
        if (m_fatal && !m_halted && q.size() == 0) begin
            m_halted = 1'b1;
        end
        if (fatal_now) begin
            m_fatal = 1'b1;
        end
        if (m_ts != 32'hFFFF_FFFF) begin
            m_ts = m_ts + 32'd1;
        end
    endtask

    task automatic compare_outputs();
        bit exp_v;
        exp_v = !m_halted && (q.size() > 0);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            check("out_level", 64'(out_level), 64'(q[0].lvl));
            check("out_topic", 64'(out_topic), 64'(q[0].topic));
            check("out_data",  64'(out_data),  64'(q[0].data));
            check("out_time",  64'(out_time),  64'(q[0].ts));
`ifdef EVENT_RECORDER_SEQ_EN
            check("out_seq",   64'(out_seq),   64'(q[0].seq));
`endif
        end else begin
            check("idle_level", 64'(out_level), 64'd0);
            check("idle_topic", 64'(out_topic), 64'd0);
            check("idle_data",  64'(out_data),  64'd0);
            check("idle_time",  64'(out_time),  64'd0);
        end
        check("error_count", 64'(error_count), 64'(m_err));
        check("drop_count",  64'(drop_count),  64'(m_drop));
        check("halt",        64'(halt),        64'(m_halted));
    endtask

    // Starts and ends on a falling edge: compare, drive, clock, advance model
    task automatic step(input logic v, input logic [2:0] lvl, input logic [7:0] topic,
                        input logic [31:0] data, input logic rdy);
        compare_outputs();
        in_valid  = v;
        in_level  = lvl;
        in_topic  = topic;
        in_data   = data;
        out_ready = rdy;
        @(posedge clk);
        model_clock(v, lvl, topic, data, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 3'd0, 8'h00, 32'h0, rdy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [2:0] lv;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and first-event latency
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_error_count", 64'(error_count), 64'd0);
        idle(5, 1'b1);
        step(1'b1, 3'd2, 8'h12, 32'hDEAD_BEEF, 1'b1);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_time", 64'(out_time), 64'd5);
        check("first_level", 64'(out_level), 64'd2);
        idle(2, 1'b1);

        // Level filter including the folded codes 6 and 7
        step(1'b1, 3'd0, 8'h01, 32'h1, 1'b1);
        step(1'b1, 3'd1, 8'h02, 32'h2, 1'b1);
        step(1'b1, 3'd3, 8'h03, 32'h3, 1'b1);
        step(1'b1, 3'd6, 8'h04, 32'h4, 1'b1);
        step(1'b1, 3'd7, 8'h05, 32'h5, 1'b1);
        idle(3, 1'b1);
        check("filter_drop_count", 64'(drop_count), 64'd0);

        // Overflow: 18 events into a 16-deep FIFO with the consumer stalled
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 3'd3, 8'(8'h40 + i), 32'(32'h1000 + i), 1'b0);
        end
        check("overflow_drop_count", 64'(drop_count), 64'd2);
        idle(20, 1'b1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 3'd2, 8'(8'h80 + i), 32'(32'h2000 + i), 1'b0);
        end
        step(1'b1, 3'd3, 8'hAB, 32'hCAFE_F00D, 1'b1);
        check("pushpop_drop_count", 64'(drop_count), 64'd2);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (out_valid) n++;
            step(1'b0, 3'd0, 8'h00, 32'h0, 1'b1);
        end
        check("pushpop_occupancy", 64'(n), 64'(DEPTH));

        // Randomised traffic without FATAL
        for (int i = 0; i < 400; i++) begin
            lv = 3'($urandom_range(0, 7));
            if (lv == 3'd5) lv = 3'd4;
            step(1'($urandom_range(0, 1)), lv, 8'($urandom), 32'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with entries queued
        idle(DEPTH + 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd4, 8'(8'hC0 + i), 32'(32'h3000 + i), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_error_count", 64'(error_count), 64'd0);
        check("midreset_drop_count", 64'(drop_count), 64'd0);
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd2, 8'h55, 32'h5555_5555, 1'b0);
        check("restart_time", 64'(out_time), 64'd0);
        idle(2, 1'b1);

        // ERROR, FATAL, then INFO which must be ignored; wait for halt
        step(1'b1, 3'd4, 8'hE0, 32'hE0E0_E0E0, 1'b0);
        step(1'b1, 3'd5, 8'hF0, 32'hF0F0_F0F0, 1'b0);
        step(1'b1, 3'd2, 8'h11, 32'h1111_1111, 1'b0);
        n = 0;
        while (!halt && n < 50) begin
            step(1'($urandom_range(0, 1)), 3'd4, 8'h22, 32'h2222_2222, 1'b1);
            n++;
        end
        check("halt_within_budget", 64'(n < 50), 64'd1);
        check("halt_set", 64'(halt), 64'd1);
        check("fatal_error_count", 64'(error_count), 64'd2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd5, 8'h33, 32'h3333_3333, 1'b1);
        end
        check("halted_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/event_recorder.md
Name: event_recorder

Overview:
- Synthesizable collector for log/assertion events raised by in-design checkers.
- Tags each event with a cycle timestamp, filters it by severity, buffers it in a FIFO, and drains it over a valid/ready stream to the bench-side logger, which writes one log line per event.
- Keeps error/drop statistics and raises a sticky `halt` after a FATAL event has been fully drained, so the bench can end the simulation cleanly.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TOPIC_W, 8, width of the topic identifier.
- DATA_W, 32, width of the event payload.
- TS_W, 32, width of the timestamp counter.
- MIN_LEVEL, 0, lowest severity accepted; lower levels are discarded silently.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  event strobe, one event per cycle; no backpressure.
- in_level  in  3  severity: 0 TRACE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5 FATAL.
- in_topic  in  TOPIC_W  topic id.
- in_data  in  DATA_W  payload.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_level  out  3  head severity, normalised to 0..5.
- out_topic  out  TOPIC_W  head topic.
- out_data  out  DATA_W  head payload.
- out_time  out  TS_W  timestamp captured at acceptance.
- error_count  out  16  ERROR+FATAL events accepted; saturating.
- drop_count  out  16  events lost to a full FIFO; saturating.
- halt  out  1  sticky end-of-run flag.

Behaviour:
- Reset is asynchronous and active-low; one clock domain (`clk`, `rst_n`).
- Reset values:
  - out_valid=0, error_count=0, drop_count=0, halt=0, timestamp=0, FIFO empty, state RUN.
  - out_level, out_topic, out_data and out_time are 0 while out_valid=0.
- Timestamp:
  - Counts cycles since reset release; +1 every cycle.
  - Saturates at all-ones; never wraps.
- Level normalisation: levels 6 and 7 are treated as TRACE (0) before filtering and storage.
- Filter: a normalised level below MIN_LEVEL is discarded; no counter changes.
- Accept condition: in_valid, level passes the filter, and state == RUN.
- Accepted event:
  - If the FIFO is not full, or a pop happens in the same cycle, the event is written with the current timestamp.
  - Otherwise the event is dropped and drop_count += 1.
- error_count += 1 for every accepted ERROR or FATAL event, whether it is stored or dropped.
- Full FIFO with simultaneous pop and push: both happen; occupancy is unchanged; drop_count is unchanged.
- Output:
  - First-word-fall-through; out_valid = FIFO not empty.
  - Pop on out_valid && out_ready.
  - An event accepted in cycle N appears at the output in cycle N+1 at the earliest.
  - Output fields hold steady while out_valid && !out_ready.
  - Entries leave in strict arrival order.
- State machine:
  - RUN -> DRAIN in the cycle after a FATAL event is accepted. This applies even if that event was dropped because the FIFO was full.
  - DRAIN: new events are ignored and no counters change; popping continues normally.
  - DRAIN -> HALTED when the FIFO is empty.
  - HALTED: halt=1 and stays set until reset. Inputs are ignored and out_valid=0.
- Reset mid-run: the FIFO contents are discarded immediately; all outputs return to their reset values asynchronously.

Optional Feature:
- Macro: EVENT_RECORDER_SEQ_EN.
- Defined:
  - Adds output port out_seq[15:0]: the sequence number of the head entry.
  - A 16-bit sequence counter increments on every accepted event, including dropped ones, and wraps at 0xFFFF -> 0.
  - Each stored entry carries its number, so the logger can detect gaps caused by drops.
- Undefined: no out_seq port, no sequence counter, FIFO width reduced accordingly.

Decomposition:
- Shared package holds:
  - Severity typedef: 3-bit enum TRACE..FATAL matching the bench tone ordering.
  - Normalisation function for levels 6 and 7.
  - Recorder state enum {RUN, DRAIN, HALTED}.
  - Counter width constant (16).
- Sub-module event_fifo:
  - Synchronous FWFT FIFO parameterised by DEPTH and entry width.
  - Exposes full/empty flags.
  - Supports a push on the same cycle as a pop when full.
- Top level holds the timestamp counter, filter, counters and state machine.

Test Plan:
- Reset release, INFO event at cycle 5 with topic 0x12, data 0xDEADBEEF, out_ready=1 -> out_valid in cycle 6 with out_time=5, out_level=2; error_count=0.
- MIN_LEVEL=2; push TRACE, DEBUG, WARN -> only WARN is emitted; drop_count=0.
- out_ready=0; push 18 events with DEPTH=16 -> 16 emitted in order after out_ready=1; drop_count=2.
  - With EVENT_RECORDER_SEQ_EN defined: out_seq runs 0..15 and 18 is the next value issued.
- FIFO full; in_valid and pop in the same cycle -> new entry stored; occupancy stays 16; drop_count unchanged.
- Push ERROR, FATAL, then INFO in the next cycle -> INFO ignored; error_count=2; halt=1 in the cycle after the FATAL entry is popped.
- Assert rst_n=0 with 5 entries queued -> out_valid=0 and all counters 0 immediately; after release the first output timestamp restarts from 0.
